// File: rtl/bbt_pkg.sv
// Shared definitions for the bounding-box traverser: default coordinate
// width and FSM state encoding.
package bbt_pkg;

   localparam int unsigned BBT_WIDTH = 32;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SCAN = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE = ST_IDLE,
      S_SCAN = ST_SCAN,
      S_DONE = ST_DONE
   } bbt_state_e;

endpackage

// File: rtl/bbt_step.sv
// Combinational raster step: given the current pixel and the clipped box
// bounds, produce the next pixel and flag the final pixel of the box.
//   x_i, y_i        current pixel
//   x0_i            row start (x wraps back here)
//   x1_i, y1_i      exclusive right / bottom bounds (always > current)
//   x_nxt_o/y_nxt_o next pixel in raster order
//   last_o          current pixel is the last one of the box
module bbt_step
   import bbt_pkg::*;
#(
   parameter int unsigned WIDTH = BBT_WIDTH
) (
   input  logic [WIDTH-1:0] x_i,
   input  logic [WIDTH-1:0] y_i,
   input  logic [WIDTH-1:0] x0_i,
   input  logic [WIDTH-1:0] x1_i,
   input  logic [WIDTH-1:0] y1_i,
   output logic [WIDTH-1:0] x_nxt_o,
   output logic [WIDTH-1:0] y_nxt_o,
   output logic             last_o
);

   logic row_end;

   // Bounds are strictly greater than the current pixel, so x1-1 / y1-1
   // never wrap and x+1 / y+1 never exceed the bound: no overflow even
   // at the top of the coordinate range.
   always_comb begin
      row_end = (x_i == (x1_i - WIDTH'(1)));
      last_o  = row_end && (y_i == (y1_i - WIDTH'(1)));
      x_nxt_o = row_end ? x0_i : (x_i + WIDTH'(1));
      y_nxt_o = row_end ? (y_i + WIDTH'(1)) : y_i;
   end

endmodule

// File: rtl/bounding_box_traverser.sv
// Bounding-box traverser: accepts a box (clipped against the screen
// resolution) and emits its pixel coordinates in raster order over a
// valid/ready stream, then pulses done.
//   clk, rst                    clock, async active-high reset
//   bb_valid/bb_ready           box handshake (ready only when idle)
//   top/bottom/left/right       box edges, bottom/right exclusive
//   resx/resy                   screen resolution, sampled with the box
//   px_valid/px_ready           pixel handshake
//   px_x/px_y/px_last           current pixel and final-pixel flag
//   done                        one-cycle pulse when a box completes
module bounding_box_traverser
   import bbt_pkg::*;
#(
   parameter int unsigned WIDTH = BBT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             bb_valid,
   output logic             bb_ready,
   input  logic [WIDTH-1:0] top,
   input  logic [WIDTH-1:0] bottom,
   input  logic [WIDTH-1:0] left,
   input  logic [WIDTH-1:0] right,
   input  logic [WIDTH-1:0] resx,
   input  logic [WIDTH-1:0] resy,
   output logic             px_valid,
   input  logic             px_ready,
   output logic [WIDTH-1:0] px_x,
   output logic [WIDTH-1:0] px_y,
   output logic             px_last,
   output logic             done
);

   bbt_state_e       state_q, state_d;
   logic [WIDTH-1:0] x0_q, x0_d;
   logic [WIDTH-1:0] x1_q, x1_d;
   logic [WIDTH-1:0] y1_q, y1_d;
   logic [WIDTH-1:0] x_q, x_d;
   logic [WIDTH-1:0] y_q, y_d;

   logic             accept;
   logic             handshake;
   logic             box_empty;
   logic [WIDTH-1:0] x1_clip;
   logic [WIDTH-1:0] y1_clip;
   logic [WIDTH-1:0] x_nxt;
   logic [WIDTH-1:0] y_nxt;
   logic             step_last;

   // Clip the offered box against the screen and classify it.
   always_comb begin
      x1_clip   = (right  < resx) ? right  : resx;
      y1_clip   = (bottom < resy) ? bottom : resy;
      box_empty = (left >= x1_clip) || (top >= y1_clip);
      accept    = bb_valid && (state_q == S_IDLE);
      handshake = (state_q == S_SCAN) && px_ready;
   end

   bbt_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .x_i     (x_q),
      .y_i     (y_q),
      .x0_i    (x0_q),
      .x1_i    (x1_q),
      .y1_i    (y1_q),
      .x_nxt_o (x_nxt),
      .y_nxt_o (y_nxt),
      .last_o  (step_last)
   );

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d = box_empty ? S_DONE : S_SCAN;
            end
         end
         S_SCAN: begin
            if (handshake && step_last) begin
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // FSM outputs; px_valid depends only on state, never on px_ready.
   always_comb begin
      bb_ready = 1'b0;
      px_valid = 1'b0;
      done     = 1'b0;
      px_last  = 1'b0;
      unique case (state_q)
         S_IDLE: bb_ready = 1'b1;
         S_SCAN: begin
            px_valid = 1'b1;
            px_last  = step_last;
         end
         S_DONE:  done = 1'b1;
         default: ;
      endcase
      px_x = x_q;
      px_y = y_q;
   end

   // Box bounds are captured only at acceptance; pixel advances on handshake.
   always_comb begin
      x0_d = x0_q;
      x1_d = x1_q;
      y1_d = y1_q;
      x_d  = x_q;
      y_d  = y_q;
      if (accept) begin
         x0_d = left;
         x1_d = x1_clip;
         y1_d = y1_clip;
         x_d  = left;
         y_d  = top;
      end else if (handshake) begin
         x_d = x_nxt;
         y_d = y_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x0_q <= '0;
         x1_q <= '0;
         y1_q <= '0;
         x_q  <= '0;
         y_q  <= '0;
      end else begin
         x0_q <= x0_d;
         x1_q <= x1_d;
         y1_q <= y1_d;
         x_q  <= x_d;
         y_q  <= y_d;
      end
   end

endmodule
